case_6_dot_acc: RTL and testbench
=================================

# case_6_dot_acc

Streaming signed accumulator that sits directly downstream of the 8-bit signed product stage. It accepts a stream of truncated 8-bit signed products under a valid/ready handshake and sums each group of LEN consecutive products into a sign-extended ACC_W-bit total. For each group it emits one result word with a sticky signed-overflow flag under a second valid/ready handshake. It turns the multiplier's per-element output into the dot-product result consumed by the writeback stage.

## Interface
- LEN, 4: products per group; legal range 1..65535.
- IN_W, 8: product width; must match the upstream multiplier's dout_WIDTH.
- ACC_W, 16: accumulator/result width; ACC_W >= IN_W.
- CNT_W, 16: element-counter width; 2^CNT_W > LEN.
- ap_clk  in  1  sole clock; all state updates on rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- in_data  in  IN_W  signed product from the multiplier.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  ACC_W  signed group sum.
- out_ovf  out  1  one or more additions in the group overflowed ACC_W.
- out_valid  out  1  out_data/out_ovf valid.
- out_ready  in  1  downstream accepts the result.

## Operation
- States (shared enum): ACCUM, HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - An input beat is accepted when in_valid && in_ready.
  - On each accepted beat: acc <= acc + sext(in_data) in ACC_W two's complement, wrapping on overflow; cnt <= cnt+1.
  - ovf is set if the operands have equal sign and the result sign differs. Once set, ovf stays set for the rest of the group.
  - On the beat where cnt==LEN-1: the final sum is written into acc, the final ovf into the ovf register, cnt clears to 0, and state moves to HOLD.
- HOLD:
  - in_ready=0, out_valid=1; out_data=acc, out_ovf=ovf.
  - out_data and out_ovf stay stable until accepted.
  - On out_ready: acc clears to 0, ovf clears to 0, state moves to ACCUM.
- in_valid while in HOLD is ignored, with no data loss because in_ready=0. The upstream must hold in_data.
- in_valid may drop mid-group. Partial sums and cnt are held, with no timeout.
- LEN=1: every accepted beat goes straight to HOLD with out_data=sext(in_data).
- Reset (any time, including mid-group or in HOLD): state=ACCUM, acc=0, cnt=0, ovf=0. The partial group is discarded.

## Timing
- Output values in reset: in_ready=1, out_valid=0, out_data=0, out_ovf=0.
  - in_ready follows the reset state directly, so it is 1 both during reset and in the ACCUM state after release.
- Latency: out_valid rises in the cycle after the LEN-th input beat is accepted.
- Throughput: one input beat per cycle within a group. Best case is LEN+1 cycles per group (one HOLD cycle when out_ready=1).
- in_ready and out_valid are pure decodes of the state register; there is no combinational path from out_ready to in_ready.
- in_ready returns to 1 in the cycle after out_valid && out_ready.
- in_data is sampled only on handshake cycles; X on in_data outside them must not propagate.

## Structure
- Shared package holds:
  - the state enum {ACCUM, HOLD};
  - the default constants IN_W=8, ACC_W=16, LEN=4;
  - the overflow-detect function (operand signs vs result sign).
- A single module holds the state register, accumulator, counter and ovf flag.
- An optional sub-module, case_6_acc_ovf_add, is natural: a combinational ACC_W sign-extending adder with overflow output. It is reused by sibling reduction stages.
- There is no input skid buffer. The upstream multiplier is combinational and its source holds data under in_ready.

## Test plan
- Basic sum (LEN=4, ACC_W=16): products 5, -3, 127, -128 with continuous valid and out_ready=1 -> one result, out_data=1, out_ovf=0, out_valid exactly 1 cycle after the 4th beat.
- Backpressure: same stream with out_ready=0 for 5 cycles -> out_valid held, out_data stable at 1, in_ready=0 throughout. A 5th product offered during HOLD is accepted only after release and becomes the first element of group 2.
- Bubbles: products -128 x4 with in_valid toggling 1,0,1,0,… -> out_data=-512 (16'hFE00), ovf=0, cnt unaffected by idle cycles.
- Overflow (ACC_W=8 build): 100, 100, -100, 0 -> out_data=100 (wraps at 200, recovers), out_ovf=1. The next group 1, 1, 1, 1 -> out_data=4, out_ovf=0, showing ovf cleared per group.
- Reset mid-group: 2 of 4 beats accepted (10, 20), then ap_rst_n low for 1 cycle, then 1, 2, 3, 4 -> out_data=10. Outputs show the reset values during reset.
- LEN=1 build: products 7, -7 back-to-back with out_ready=1 -> two results, 7 then -7, each one cycle after acceptance, in_ready pattern 1,0,1,0.

Source files
------------

// File: rtl/case_6_dot_acc_pkg.sv
// Shared definitions for the signed dot-product accumulator and its sibling
// reduction stages.
//   - state_e   : group accumulate / result hold states
//   - DEF_*     : default build constants (product width, result width, group length)
//   - add_ovf() : two's complement overflow detect from operand and result signs
package case_6_dot_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_ACC_W = 16;
    localparam int DEF_LEN   = 4;
    localparam int DEF_CNT_W = 16;

    // Signed addition overflowed when both operands share a sign and the
    // result sign differs from it.
    function automatic logic add_ovf(input logic a_sign,
                                     input logic b_sign,
                                     input logic r_sign);
        return (a_sign == b_sign) && (r_sign != a_sign);
    endfunction

endpackage

// File: rtl/case_6_acc_ovf_add.sv
// Combinational sign-extending adder with signed overflow output.
// Ports:
//   acc_i : ACC_W signed running sum
//   din_i : IN_W signed addend, sign-extended to ACC_W
//   sum_o : ACC_W signed wrapped sum
//   ovf_o : this addition overflowed ACC_W
module case_6_acc_ovf_add
    import case_6_dot_acc_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [ACC_W-1:0] sum_o,
    output logic                    ovf_o
);

    logic signed [ACC_W-1:0] din_ext;

    assign din_ext = ACC_W'(din_i);
    assign sum_o   = acc_i + din_ext;
    assign ovf_o   = add_ovf(acc_i[ACC_W-1], din_ext[ACC_W-1], sum_o[ACC_W-1]);

endmodule

// File: rtl/case_6_dot_acc.sv
// Streaming signed accumulator: sums each group of LEN signed products into an
// ACC_W-bit total and presents one result per group with a sticky overflow flag.
// Ports:
//   ap_clk    : clock, rising edge
//   ap_rst_n  : asynchronous active-low reset
//   in_data   : IN_W signed product       in_valid / in_ready : input handshake
//   out_data  : ACC_W signed group sum    out_ovf : group overflowed
//   out_valid / out_ready                 : result handshake
module case_6_dot_acc
    import case_6_dot_acc_pkg::*;
#(
    parameter int LEN   = DEF_LEN,
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_ovf,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q,   acc_d;
    logic        [CNT_W-1:0] cnt_q,   cnt_d;
    logic                    ovf_q,   ovf_d;

    logic signed [ACC_W-1:0] sum_w;
    logic                    add_ovf_w;

    case_6_acc_ovf_add #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_add (
        .acc_i (acc_q),
        .din_i (in_data),
        .sum_o (sum_w),
        .ovf_o (add_ovf_w)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                // in_ready is 1 throughout ACCUM, so in_valid alone is the handshake;
                // the adder output is only consumed on that cycle.
                if (in_valid) begin
                    acc_d = sum_w;
                    ovf_d = ovf_q | add_ovf_w;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode only the state register, keeping out_ready
    // off any combinational path to in_ready.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_case_6_dot_acc.sv
module tb_case_6_dot_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Three builds: 0 = LEN4/ACC16, 1 = LEN4/ACC8, 2 = LEN1/ACC16
    logic [2:0]      rst_n;
    logic [2:0]      in_valid;
    logic [2:0]      out_ready;
    logic signed [7:0] in_data [3];
    wire  [2:0]      in_ready;
    wire  [2:0]      out_valid;
    wire  [2:0]      out_ovf;
    wire signed [15:0] od0;
    wire signed [7:0]  od1;
    wire signed [15:0] od2;

    case_6_dot_acc #(.LEN(4), .IN_W(8), .ACC_W(16), .CNT_W(16)) u_acc16 (
        .ap_clk(clk), .ap_rst_n(rst_n[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .out_data(od0), .out_ovf(out_ovf[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]));

    case_6_dot_acc #(.LEN(4), .IN_W(8), .ACC_W(8), .CNT_W(16)) u_acc8 (
        .ap_clk(clk), .ap_rst_n(rst_n[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .out_data(od1), .out_ovf(out_ovf[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]));

    case_6_dot_acc #(.LEN(1), .IN_W(8), .ACC_W(16), .CNT_W(16)) u_len1 (
        .ap_clk(clk), .ap_rst_n(rst_n[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .out_data(od2), .out_ovf(out_ovf[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]));

    int n_vec = 0;
    int n_err = 0;

    int len_m [3] = '{4, 4, 1};
    int aw_m  [3] = '{16, 8, 16};

    function automatic int get_od(int k);
        case (k)
            0:       return int'(od0);
            1:       return int'(od1);
            default: return int'(od2);
        endcase
    endfunction

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reduce an exact integer sum into the signed range of a w-bit register.
    function automatic int wrapw(longint t, int w);
        longint m;
        longint r;
        m = 64'sd1 << w;
        r = t % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return int'(r);
    endfunction

    // ---------------- behavioural reference model ----------------
    // Per build: whether a finished group is waiting, its exact-range-checked
    // running sum, the number of elements taken so far, and the overflow flag.
    bit hold_m [3];
    int sum_m  [3];
    int cnt_m  [3];
    bit ovf_m  [3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            hold_m[k] = 0; sum_m[k] = 0; cnt_m[k] = 0; ovf_m[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n[k]) begin
                    hold_m[k] = 0; sum_m[k] = 0; cnt_m[k] = 0; ovf_m[k] = 0;
                    check($sformatf("dut%0d rst in_ready", k), int'(in_ready[k]), 1);
                    check($sformatf("dut%0d rst out_valid", k), int'(out_valid[k]), 0);
                    check($sformatf("dut%0d rst out_data", k), get_od(k), 0);
                    check($sformatf("dut%0d rst out_ovf", k), int'(out_ovf[k]), 0);
                end else begin
                    check($sformatf("dut%0d in_ready", k), int'(in_ready[k]), int'(!hold_m[k]));
                    check($sformatf("dut%0d out_valid", k), int'(out_valid[k]), int'(hold_m[k]));
                    if (hold_m[k]) begin
                        check($sformatf("dut%0d out_data", k), get_od(k), sum_m[k]);
                        check($sformatf("dut%0d out_ovf", k), int'(out_ovf[k]), int'(ovf_m[k]));
                    end
                    // Inputs are stable from here to the next rising edge.
                    if (!hold_m[k]) begin
                        if (in_valid[k]) begin
                            longint t;
                            longint lim;
                            t   = longint'(sum_m[k]) + longint'(in_data[k]);
                            lim = 64'sd1 << (aw_m[k] - 1);
                            if (t >= lim || t < -lim) ovf_m[k] = 1;
                            sum_m[k] = wrapw(t, aw_m[k]);
                            cnt_m[k]++;
                            if (cnt_m[k] == len_m[k]) begin
                                hold_m[k] = 1;
                                cnt_m[k]  = 0;
                            end
                        end
                    end else if (out_ready[k]) begin
                        hold_m[k] = 0; sum_m[k] = 0; ovf_m[k] = 0;
                    end
                end
            end
        end
    end

    // ---------------- directed vector table ----------------
    // Expected values describe the outputs seen in the cycle the row's inputs apply.
    typedef struct {
        int k;
        bit rst;
        bit vld;
        int data;
        bit rdy;
        bit e_ir;
        bit e_ov;
        bit chk;
        int e_od;
        bit e_ovf;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(int k, bit rst, bit vld, int d, bit rdy, bit eir, bit eov,
                                bit chk = 0, int eod = 0, bit eovf = 0);
        vec_t v;
        v.k = k; v.rst = rst; v.vld = vld; v.data = d; v.rdy = rdy;
        v.e_ir = eir; v.e_ov = eov; v.chk = chk; v.e_od = eod; v.e_ovf = eovf;
        tbl.push_back(v);
    endfunction

    initial begin
        rst_n     = '1;
        in_valid  = '0;
        out_ready = '1;
        for (int k = 0; k < 3; k++) in_data[k] = '0;
        #1 rst_n = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = '1;

        // Basic sum: 5 - 3 + 127 - 128 = 1
        add(0,1,1,5,1,1,0); add(0,1,1,-3,1,1,0); add(0,1,1,127,1,1,0); add(0,1,1,-128,1,1,0);
        add(0,1,0,0,1,0,1,1,1,0);
        // Backpressure: result held five cycles, 9 waits and then opens group 2
        add(0,1,1,5,0,1,0); add(0,1,1,-3,0,1,0); add(0,1,1,127,0,1,0); add(0,1,1,-128,0,1,0);
        for (int i = 0; i < 5; i++) add(0,1,1,9,0,0,1,1,1,0);
        add(0,1,1,9,1,0,1,1,1,0);
        add(0,1,1,9,1,1,0); add(0,1,1,1,1,1,0); add(0,1,1,1,1,1,0); add(0,1,1,1,1,1,0);
        add(0,1,0,0,1,0,1,1,12,0);
        // Bubbles: -128 x4 with idle cycles between
        for (int i = 0; i < 3; i++) begin add(0,1,1,-128,1,1,0); add(0,1,0,0,1,1,0); end
        add(0,1,1,-128,1,1,0);
        add(0,1,0,0,1,0,1,1,-512,0);
        // Overflow on the 8-bit build, then a clean group
        add(1,1,1,100,1,1,0); add(1,1,1,100,1,1,0); add(1,1,1,-100,1,1,0); add(1,1,1,0,1,1,0);
        add(1,1,0,0,1,0,1,1,100,1);
        add(1,1,1,1,1,1,0); add(1,1,1,1,1,1,0); add(1,1,1,1,1,1,0); add(1,1,1,1,1,1,0);
        add(1,1,0,0,1,0,1,1,4,0);
        // Reset mid-group discards 10 + 20
        add(0,1,1,10,1,1,0); add(0,1,1,20,1,1,0);
        add(0,0,0,0,1,1,0,1,0,0);
        add(0,1,1,1,1,1,0); add(0,1,1,2,1,1,0); add(0,1,1,3,1,1,0); add(0,1,1,4,1,1,0);
        add(0,1,0,0,1,0,1,1,10,0);
        // LEN=1: in_ready 1,0,1,0
        add(2,1,1,7,1,1,0); add(2,1,1,-7,1,0,1,1,7,0);
        add(2,1,1,-7,1,1,0); add(2,1,0,0,1,0,1,1,-7,0);

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                rst_n[k] = 1'b1; in_valid[k] = 1'b0; out_ready[k] = 1'b1;
                in_data[k] = 8'($urandom);
            end
            rst_n[tbl[i].k]     = tbl[i].rst;
            in_valid[tbl[i].k]  = tbl[i].vld;
            out_ready[tbl[i].k] = tbl[i].rdy;
            in_data[tbl[i].k]   = 8'(tbl[i].data);
            @(negedge clk);
            #1;
            check($sformatf("row%0d in_ready", i), int'(in_ready[tbl[i].k]), int'(tbl[i].e_ir));
            check($sformatf("row%0d out_valid", i), int'(out_valid[tbl[i].k]), int'(tbl[i].e_ov));
            if (tbl[i].chk) begin
                check($sformatf("row%0d out_data", i), get_od(tbl[i].k), tbl[i].e_od);
                check($sformatf("row%0d out_ovf", i), int'(out_ovf[tbl[i].k]), int'(tbl[i].e_ovf));
            end
        end

        // ---------------- randomized traffic against the model ----------------
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                rst_n[k]     = ($urandom_range(0, 99) != 0);
                in_valid[k]  = ($urandom_range(0, 3) != 0);
                out_ready[k] = ($urandom_range(0, 2) != 0);
                in_data[k]   = 8'($urandom);
            end
        end

        @(posedge clk);
        #1;
        rst_n = '1; in_valid = '0; out_ready = '1;
        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
